// File: rtl/rs232_pkg.sv
// rs232_pkg: shared receiver state type, default timing constant and a
// parity helper. The build option RS232_RX_PARITY_EN adds the PARITY state.
package rs232_pkg;

    // 27 MHz / 115200 baud, rounded to the nearest whole clock count.
    localparam int DEFAULT_CLKS_PER_BIT = 234;

    // Number of payload bits in one character.
    localparam int DATA_BITS = 8;

    // Receiver frame states. PARITY only exists when parity is built in.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef RS232_RX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } rx_state_e;

    // Even parity holds when the eight data bits plus the parity bit
    // contain an even number of ones.
    function automatic logic even_parity_ok(input logic [7:0] d, input logic p);
        return ~^{d, p};
    endfunction

endpackage

// File: rtl/rs232_sync.sv
// rs232_sync: two-flop synchronizer for the asynchronous serial line.
// Both flops reset to 1 so a reset never looks like a start bit.
module rs232_sync (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic async_i,
    output logic sync_o
);

    logic meta_q;
    logic sync_q;

    // Shift the raw line through two flops to settle metastability.
    always_ff @(posedge clk_i) begin
        // NOTE: clocked state uses non-blocking assignments so every flop
        // samples the pre-edge value of the flop before it.
        if (!rst_n_i) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/rs232_rx.sv
// rs232_rx: 8N1 RS-232 receiver with a one-entry output holding register,
// framing-error and overrun pulses. Defining RS232_RX_PARITY_EN adds an
// even-parity bit after the data and a parity_err pulse output.
module rs232_rx
    import rs232_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clock_27mhz,
    input  logic       reset_b,
    input  logic       rs232_rxd,
    output logic [7:0] data,
    output logic       data_valid,
    input  logic       data_ready,
    output logic       frame_err,
    output logic       overrun,
`ifdef RS232_RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic       busy
);

    // One spare bit keeps the counter from wrapping inside a bit period.
    localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);

    logic             rxd_s;

    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             data_valid_q, data_valid_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;
    logic             parity_ok;
`ifdef RS232_RX_PARITY_EN
    logic             par_bit_q, par_bit_d;
    logic             parity_err_q, parity_err_d;
`endif

    rs232_sync u_sync (
        .clk_i   (clock_27mhz),
        .rst_n_i (reset_b),
        .async_i (rs232_rxd),
        .sync_o  (rxd_s)
    );

    // Next-state logic: frame sequencing, bit sampling and output register.
    always_comb begin
        // NOTE: every variable gets a default before the case so that no
        // path leaves one unassigned, which would infer a latch.
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        data_d       = data_q;
        data_valid_d = data_valid_q;
        frame_err_d  = 1'b0;
        overrun_d    = 1'b0;
`ifdef RS232_RX_PARITY_EN
        par_bit_d    = par_bit_q;
        parity_err_d = 1'b0;
        parity_ok    = even_parity_ok(shift_q, par_bit_q);
`else
        parity_ok    = 1'b1;
`endif

        // The consumer takes the held byte on any cycle it is offered.
        if (data_valid_q && data_ready) begin
            data_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                cnt_d     = '0;
                bit_idx_d = '0;
                if (!rxd_s) begin
                    state_d = ST_START;
                end
            end

            // Re-check the start bit half a bit in to reject glitches.
            ST_START: begin
                if (cnt_q == HALF_CNT) begin
                    cnt_d   = '0;
                    state_d = rxd_s ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            // LSB arrives first, so shift right and insert at the top.
            ST_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rxd_s, shift_q[7:1]};
                    if (bit_idx_q == LAST_BIT) begin
                        bit_idx_d = '0;
`ifdef RS232_RX_PARITY_EN
                        state_d   = ST_PARITY;
`else
                        state_d   = ST_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

`ifdef RS232_RX_PARITY_EN
            ST_PARITY: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d     = '0;
                    par_bit_d = rxd_s;
                    state_d   = ST_STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif

            // Judge the frame on the stop sample; a framing error wins
            // over a parity error, and only a clean frame reaches data.
            ST_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                    if (!rxd_s) begin
                        frame_err_d = 1'b1;
                    end else if (!parity_ok) begin
`ifdef RS232_RX_PARITY_EN
                        parity_err_d = 1'b1;
`endif
                    end else if (data_valid_q && !data_ready) begin
                        overrun_d = 1'b1;
                    end else begin
                        data_d       = shift_q;
                        data_valid_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clock_27mhz) begin
        if (!reset_b) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            data_q       <= '0;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef RS232_RX_PARITY_EN
            par_bit_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            data_q       <= data_d;
            data_valid_q <= data_valid_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
`ifdef RS232_RX_PARITY_EN
            par_bit_q    <= par_bit_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign data       = data_q;
    assign data_valid = data_valid_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign busy       = (state_q != ST_IDLE);
`ifdef RS232_RX_PARITY_EN
    assign parity_err = parity_err_q;
`endif

endmodule
